// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for NUM_MASTERS active-low requesters sharing one bus.
// Grants are tenure-limited and separated by a one-cycle release slot.
module rr_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned OWN_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame,
  input  logic                   irdy,
  input  logic [NUM_MASTERS-1:0] req_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [OWN_W-1:0]       owner,
  output logic                   busy,
  output logic                   timeout_evt
);

  localparam int unsigned CntW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = (MAX_BURST == 0) ? '1 : CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e          state_q;
  logic [OWN_W-1:0] cur_q;
  logic [OWN_W-1:0] ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             tmo_q;

  logic             done;
  logic             withdrawn;
  logic             at_limit;
  logic             exit_grant;
  logic             found;
  logic [OWN_W-1:0] win;
  logic [OWN_W-1:0] win_next;
  logic [OWN_W:0]   idx;

  assign done       = frame & irdy;
  assign withdrawn  = req_n[cur_q];
  assign at_limit   = (MAX_BURST != 0) && (cnt_q == CntMax);
  assign exit_grant = done | withdrawn | at_limit;
  assign win_next   = (win == OWN_W'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;

  // Scan requests starting at ptr_q, wrapping modulo NUM_MASTERS; first low bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = {1'b0, ptr_q} + (OWN_W + 1)'(k);
      if (idx >= (OWN_W + 1)'(NUM_MASTERS)) idx = idx - (OWN_W + 1)'(NUM_MASTERS);
      if (!found && !req_n[idx[OWN_W-1:0]]) begin
        found = 1'b1;
        win   = idx[OWN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      gnt_n       <= '1;
      owner       <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      // Outputs are a registered decode of the current state.
      gnt_n       <= '1;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
      if (state_q == StGrant) begin
        gnt_n[cur_q] <= 1'b0;
        busy         <= 1'b1;
        owner        <= cur_q;
      end
      if (state_q == StRelease) timeout_evt <= tmo_q;

      unique case (state_q)
        StIdle: begin
          if (found) begin
            cur_q   <= win;
            ptr_q   <= win_next;
            cnt_q   <= CntW'(1);
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (exit_grant) begin
            // Only a pure timeout is flagged; a coinciding done/withdraw is a normal exit.
            tmo_q   <= at_limit & ~done & ~withdrawn;
            state_q <= StRelease;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomised and directed checks of rr_bus_arbiter (3-master/burst-4 and
// 8-master/no-timeout instances) against a tenure-level reference model.
module tb_rr_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame = 1'b0;
  logic       irdy = 1'b0;
  logic [2:0] req3 = '1;
  logic [7:0] req8 = '1;

  logic [2:0] gnt3;
  logic [1:0] owner3;
  logic       busy3;
  logic       tmo3;
  logic [7:0] gnt8;
  logic [2:0] owner8;
  logic       busy8;
  logic       tmo8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.NUM_MASTERS(3), .MAX_BURST(4)) dut3 (
    .clk(clk), .reset(reset), .frame(frame), .irdy(irdy), .req_n(req3),
    .gnt_n(gnt3), .owner(owner3), .busy(busy3), .timeout_evt(tmo3)
  );

  rr_bus_arbiter #(.NUM_MASTERS(8), .MAX_BURST(0)) dut8 (
    .clk(clk), .reset(reset), .frame(frame), .irdy(irdy), .req_n(req8),
    .gnt_n(gnt8), .owner(owner8), .busy(busy8), .timeout_evt(tmo8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: who holds the bus, how long, whether a release slot is pending.
  typedef struct packed {
    int          holder;   // -1 when nobody holds the bus
    int          tenure;
    bit          rel;
    int          ptr;
    bit          tmo_pend;
    logic [15:0] gnt;
    int          owner;
    bit          busy;
    bit          tmo;
  } mdl_t;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.holder = -1; r.tenure = 0; r.rel = 1'b0; r.ptr = 0; r.tmo_pend = 1'b0;
    r.gnt = 16'hFFFF; r.owner = 0; r.busy = 1'b0; r.tmo = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int n, input int mb,
                                    input logic [15:0] req, input bit dn);
    mdl_t r = m;
    r.busy = (m.holder >= 0);
    r.gnt  = 16'hFFFF;
    if (m.holder >= 0) begin
      r.gnt[m.holder] = 1'b0;
      r.owner = m.holder;
    end
    r.tmo = m.rel && m.tmo_pend;
    if (m.rel) begin
      r.rel = 1'b0;
    end else if (m.holder >= 0) begin
      bit limit = (mb != 0) && (m.tenure == mb);
      if (dn || req[m.holder] || limit) begin
        r.tmo_pend = limit && !dn && !req[m.holder];
        r.holder = -1;
        r.rel = 1'b1;
      end else if (mb == 0 || m.tenure < mb) begin
        r.tenure = m.tenure + 1;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int id = (m.ptr + k) % n;
        if (!req[id]) begin
          r.holder = id; r.tenure = 1; r.ptr = (id + 1) % n;
          break;
        end
      end
    end
    return r;
  endfunction

  mdl_t m3;
  mdl_t m8;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m3 <= mdl_rst();
      m8 <= mdl_rst();
    end else begin
      if (m3.holder < 0 && !m3.rel) check("req3_known", 32'($isunknown(req3)), 32'd0);
      if (m8.holder < 0 && !m8.rel) check("req8_known", 32'($isunknown(req8)), 32'd0);
      m3 <= mdl_step(m3, 3, 4, {13'h1FFF, req3}, frame && irdy);
      m8 <= mdl_step(m8, 8, 0, {8'hFF, req8}, frame && irdy);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!$isunknown(reset)) begin
      check("gnt3", 32'(gnt3), 32'(m3.gnt[2:0]));
      check("owner3", 32'(owner3), 32'(m3.owner));
      check("busy3", 32'(busy3), 32'(m3.busy));
      check("tmo3", 32'(tmo3), 32'(m3.tmo));
      check("gnt8", 32'(gnt8), 32'(m8.gnt[7:0]));
      check("owner8", 32'(owner8), 32'(m8.owner));
      check("busy8", 32'(busy8), 32'(m8.busy));
      check("tmo8", 32'(tmo8), 32'(m8.tmo));
    end
  end

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_busy(input bit which8, input bit val, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which8 ? busy8 : busy3) === val) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: wait expired, busy never reached %0b", name, val);
    end
  endtask

  logic [2:0] exp_a [8] = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b110};
  bit         exp_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int         exp_seq [4] = '{0, 1, 2, 0};

  initial begin
    int seq[$];
    int gap;
    int run;
    bit tmo_seen;

    #1 reset = 1'b1;
    req3 = 3'b110;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Master 0 held: grant two cycles after release, 4-cycle tenure, timeout pulse.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("a_gnt", 32'(gnt3), 32'(exp_a[i]));
      check("a_tmo", 32'(tmo3), 32'(exp_t[i]));
      if (i == 1) begin
        check("a_busy", 32'(busy3), 32'd1);
        check("a_owner", 32'(owner3), 32'd0);
      end
    end

    // Master 1 times out; master 2 is next in rotation.
    do_reset();
    req3 = 3'b101;
    wait_busy(1'b0, 1'b1, "b1_grant");
    check("b1_owner", 32'(owner3), 32'd1);
    req3 = 3'b000;
    wait_busy(1'b0, 1'b0, "b1_release");
    wait_busy(1'b0, 1'b1, "b1_regrant");
    check("b1_next_owner", 32'(owner3), 32'd2);

    // All requesting, done coinciding with the burst limit: rotation, no timeout pulse.
    do_reset();
    req3 = 3'b000;
    gap = 0; run = 0; tmo_seen = 1'b0;
    for (int i = 0; i < 80 && seq.size() < 4; i++) begin
      @(negedge clk);
      frame = 1'b0; irdy = 1'b0;
      if (tmo3) tmo_seen = 1'b1;
      if (busy3) begin
        if (run == 0) begin
          seq.push_back(int'(owner3));
          if (seq.size() > 1) check("handover_gap", 32'(gap), 32'd2);
        end
        run++; gap = 0;
        if (run == 3) begin frame = 1'b1; irdy = 1'b1; end
      end else begin
        run = 0;
        if (gnt3 == 3'b111) gap++;
      end
    end
    frame = 1'b0; irdy = 1'b0;
    check("rot_count", 32'(seq.size()), 32'd4);
    if (seq.size() == 4)
      for (int i = 0; i < 4; i++) check("rot_order", 32'(seq[i]), 32'(exp_seq[i]));
    check("coincide_no_tmo", 32'(tmo_seen), 32'd0);

    // Withdrawal mid-tenure.
    do_reset();
    req3 = 3'b110;
    wait_busy(1'b0, 1'b1, "c_grant");
    req3 = 3'b111;
    @(negedge clk);
    check("c_hold", 32'(gnt3), 32'(3'b110));
    @(negedge clk);
    check("c_gnt", 32'(gnt3), 32'(3'b111));
    check("c_tmo", 32'(tmo3), 32'd0);

    // Eight masters: move ptr to 7, then requests on 7 and 0.
    do_reset();
    req8 = 8'hBF;
    wait_busy(1'b1, 1'b1, "e_grant6");
    check("e_owner6", 32'(owner8), 32'd6);
    req8 = 8'hFF;
    wait_busy(1'b1, 1'b0, "e_rel6");
    req8 = 8'h7E;
    wait_busy(1'b1, 1'b1, "e_grant7");
    check("e_owner7", 32'(owner8), 32'd7);
    frame = 1'b1; irdy = 1'b1;
    @(negedge clk);
    frame = 1'b0; irdy = 1'b0;
    wait_busy(1'b1, 1'b0, "e_rel7");
    wait_busy(1'b1, 1'b1, "e_grant0");
    check("e_owner0", 32'(owner8), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("e_rst_gnt", 32'(gnt8), 32'h0FF);
    check("e_rst_owner", 32'(owner8), 32'd0);
    check("e_rst_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req8 = 8'hFF;

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req3 = 3'($urandom & $urandom);
      if ($urandom_range(3) == 0) req8 = 8'($urandom & $urandom);
      frame = ($urandom_range(5) == 0);
      irdy  = 1'($urandom_range(1));
      if ($urandom_range(499) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
